rd_control: RTL and testbench
=============================

# rd_control

Read-side counterpart to the array write controller. On a single `active` pulse it produces the diagonally skewed per-lane read enables and per-lane read addresses, so that a `width_height`-lane memory array streams a tile into the systolic array with lane *i* delayed *i* cycles behind lane 0. It sits between the top-level sequencer, which issues `active`, `base_addr` and consumes `done`, and the memory array, which receives `rd_en` and `rd_addr`.

## Interface
- `width_height`, default 16: number of lanes, which is also the tile depth read per lane.
- `data_width` (localparam) = 8 × `width_height`: width of the packed address bus.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `active`  input  1  start request; sampled on the rising edge; accepted only in IDLE.
- `base_addr`  input  8  first address read by every lane; captured when `active` is accepted.
- `rd_en`  output  `width_height`  per-lane read enable; bit *i* is lane *i*.
- `rd_addr`  output  `data_width`  packed per-lane address; lane *i* occupies bits [8i+7:8i].
- `busy`  output  1  high while in FILL or DRAIN.
- `done`  output  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: `rd_en` = 0.
  - FILL: shift ones into `rd_en`.
  - DRAIN: shift zeros into `rd_en`.
- IDLE → FILL when `active` = 1:
  - All lane addresses are loaded with `base_addr`.
  - `rd_en` becomes 1.
- FILL, each edge:
  - `rd_en` ← (`rd_en` << 1) | 1.
  - When `rd_en` reaches all-ones, the state goes to DRAIN on that same edge.
- DRAIN, each edge: `rd_en` ← `rd_en` << 1.
- DRAIN → IDLE on the edge where `rd_en` becomes 0. On that edge:
  - `done` ← 1.
  - All lane addresses are cleared to 0.
- Per-lane address update: on every edge where lane *i*'s `rd_en` bit is currently 1, lane *i*'s address increments by 1. Lane *i* therefore presents `base_addr`+j during its j-th enabled cycle, for j = 0..`width_height`−1.
- Address arithmetic is 8-bit modulo 256; `base_addr`+j wraps with no flag.
- `active` while `busy` = 1 is ignored. It is not queued, and `base_addr` is not re-sampled.
- Each lane is enabled for exactly `width_height` consecutive cycles.
- The total number of cycles with `rd_en` ≠ 0 is 2×`width_height`−1.
- `done` is registered and deasserts the following edge unless a new run completes.

## Timing
- Reset values (asynchronous, applied immediately when `reset` = 0):
  - state = IDLE, `rd_en` = 0, `rd_addr` = 0, `busy` = 0, `done` = 0.
- Reset mid-run aborts it:
  - No `done` pulse is produced.
  - Outputs stay at their reset values until `active` is accepted after `reset` returns high.
- Latency from `active` (sampled at edge E):
  - `rd_en` = 1 and lane-0 address = `base_addr` are visible after E.
  - All-ones `rd_en` first appears after edge E+`width_height`−1.
  - `rd_en` = 0 with `done` = 1 appears after edge E+2×`width_height`−1.
- Back-to-back runs:
  - `active` asserted in the `done` cycle (state IDLE) is accepted on the next edge.
  - Between runs there is exactly one cycle with `rd_en` = 0.
- `busy` goes high after edge E and low on the same edge that raises `done`.
- Lanes whose enable bit is 0 hold their address. Memory must ignore `rd_addr` lanes whose `rd_en` bit is 0.

## Test plan
Scenarios 1, 2, 4, 5 and 6 use `width_height` = 4; scenario 3 uses the default 16.
1. Basic run, `base_addr` = 0x10, `active` pulsed for 1 cycle:
   - `rd_en` sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, then 0000 with `done` = 1 for exactly one cycle.
   - Lane 0 addresses 0x10–0x13 on its 4 enabled cycles; lane 3 addresses 0x10–0x13 on cycles 4–7.
2. Wrap, `base_addr` = 0xFE:
   - Every lane reads 0xFE, 0xFF, 0x00, 0x01 in order.
   - `done` timing is unchanged.
3. Default `width_height` = 16, `base_addr` = 0:
   - 31 cycles with nonzero `rd_en`, peaking at 16'hFFFF.
   - Lane 15 reads 0–15 on cycles 16–31; `done` appears on cycle 32.
4. `active` held high continuously, `base_addr` changed to 0x40 mid-run:
   - The first run completes with its original addresses.
   - The second run starts on the edge after `done`, reads from 0x40, and has exactly one idle gap cycle.
5. `reset` driven low during cycle 5 of a run:
   - All outputs go to 0 immediately; no `done` pulse.
   - A subsequent `active` produces a clean run identical to scenario 1.
6. `active` asserted only at cycle 3 while busy:
   - Ignored; a single `done` is produced and no second run starts.

Source files
------------

// File: rtl/rd_control.sv
// ---------------------------------------------------------------------------
// rd_control
//   Read-side sequencer for a width_height-lane memory array feeding a
//   systolic array. A single accepted `active` pulse starts a run. rd_en
//   ramps up as a diagonal wavefront (FILL) and then back down (DRAIN), so
//   lane i trails lane 0 by i cycles. Each lane's address starts at
//   base_addr and steps by one on every cycle that lane is enabled.
//
// Ports
//   clk        in   1                rising-edge clock
//   reset      in   1                asynchronous reset, active low
//   active     in   1                start request, honoured only in IDLE
//   base_addr  in   8                first address read by every lane
//   rd_en      out  width_height     per-lane read enable, bit i = lane i
//   rd_addr    out  8*width_height   packed lane addresses, lane i = [8i+7:8i]
//   busy       out  1                high during FILL and DRAIN
//   done       out  1                one-cycle pulse at the end of a run
// ---------------------------------------------------------------------------

// Per-lane address counter. A clear has priority over a load, and a load
// has priority over an increment.
module rd_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [7:0] i_base,
    output logic [7:0] o_addr
);
    logic [7:0] r_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_addr <= 8'd0;
        else if (i_clear)
            r_addr <= 8'd0;
        else if (i_load)
            r_addr <= i_base;
        else if (i_en)
            r_addr <= r_addr + 8'd1;   // wraps modulo 256
    end

    assign o_addr = r_addr;
endmodule

module rd_control #(
    parameter  int width_height = 16,
    localparam int data_width   = 8 * width_height
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active,
    input  logic [7:0]              base_addr,
    output logic [width_height-1:0] rd_en,
    output logic [data_width-1:0]   rd_addr,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                  r_state;
    logic [width_height-1:0] r_en;
    logic                    r_busy;
    logic                    r_done;

    logic [width_height-1:0] w_one;
    logic [width_height-1:0] w_fill_nxt;
    logic [width_height-1:0] w_drain_nxt;
    logic                    w_load;
    logic                    w_clear;

    assign w_one       = width_height'(1);
    assign w_fill_nxt  = (r_en << 1) | w_one;
    assign w_drain_nxt = r_en << 1;
    assign w_load      = (r_state == IDLE) && active;
    // The edge that empties rd_en also returns every lane address to zero.
    assign w_clear     = (r_state == DRAIN) && (w_drain_nxt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_en    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (active) begin
                        r_en    <= w_one;
                        r_busy  <= 1'b1;
                        // A single-lane array is already full after the load.
                        r_state <= (w_one == '1) ? DRAIN : FILL;
                    end
                end
                FILL: begin
                    r_en <= w_fill_nxt;
                    if (w_fill_nxt == '1)
                        r_state <= DRAIN;
                end
                DRAIN: begin
                    r_en <= w_drain_nxt;
                    if (w_drain_nxt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < width_height; g++) begin : g_lane
        rd_lane u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_load  (w_load),
            .i_clear (w_clear),
            .i_en    (r_en[g]),
            .i_base  (base_addr),
            .o_addr  (rd_addr[8*g +: 8])
        );
    end

    assign rd_en = r_en;
    assign busy  = r_busy;
    assign done  = r_done;
endmodule

// File: tb/tb_rd_control.sv
module tb_rd_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         act4, act16;
    logic [7:0]   base4, base16;
    logic [3:0]   en4;
    logic [31:0]  addr4;
    logic         busy4, done4;
    logic [15:0]  en16;
    logic [127:0] addr16;
    logic         busy16, done16;

    int total = 0;
    int bad   = 0;

    logic [3:0] EXP_EN [0:7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    rd_control #(.width_height(4)) dut4 (
        .clk(clk), .reset(reset), .active(act4), .base_addr(base4),
        .rd_en(en4), .rd_addr(addr4), .busy(busy4), .done(done4)
    );

    rd_control #(.width_height(16)) dut16 (
        .clk(clk), .reset(reset), .active(act16), .base_addr(base16),
        .rd_en(en16), .rd_addr(addr16), .busy(busy16), .done(done16)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One width-4 run, assumed to start from IDLE. base_mid is driven onto
    // base_addr after the second edge; hold keeps active high throughout;
    // poke_k raises active for one edge while the run is busy.
    task automatic run4(input string tag, input logic [7:0] base, input logic [7:0] base_mid,
                        input bit hold, input int poke_k);
        logic [7:0] e;
        base4 = base;
        act4  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0 && !hold) act4 = 1'b0;
            if (k == 1) base4 = base_mid;
            if (k == poke_k) act4 = 1'b1;
            else if (k == poke_k + 1 && !hold) act4 = 1'b0;
            chk({tag, "_en"},   en4,   EXP_EN[k]);
            chk({tag, "_done"}, done4, (k == 7));
            chk({tag, "_busy"}, busy4, (k < 7));
            for (int i = 0; i < 4; i++) begin
                if (k >= i && k <= i + 3) begin
                    e = base + 8'(k - i);
                    chk($sformatf("%s_lane%0d_k%0d", tag, i, k), addr4[8*i +: 8], e);
                end
            end
            if (k == 7) chk({tag, "_addr_clr"}, addr4, 32'h0);
        end
    endtask

    initial begin
        int         nz;
        logic [15:0] e16;

        reset = 1'b0; act4 = 1'b0; act16 = 1'b0; base4 = 8'h00; base16 = 8'h00;
        #12;
        chk("rst_en4",   en4,    4'h0);
        chk("rst_addr4", addr4,  32'h0);
        chk("rst_busy4", busy4,  1'b0);
        chk("rst_done4", done4,  1'b0);
        chk("rst_en16",  en16,   16'h0);
        chk("rst_addr16", addr16, 128'h0);
        reset = 1'b1;
        step();
        chk("idle_en4", en4, 4'h0);

        // Basic run, then a wrap run issued in the done cycle (back-to-back)
        run4("s1", 8'h10, 8'h10, 1'b0, -1);
        run4("s2", 8'hFE, 8'hFE, 1'b0, -1);
        step();
        chk("s2_after_en", en4, 4'h0);

        // Default width, base 0
        act16 = 1'b1; base16 = 8'h00; nz = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (k == 0) act16 = 1'b0;
            if (k < 16) e16 = 16'((32'd1 << (k + 1)) - 1);
            else        e16 = 16'(32'hFFFF << (k - 15));
            if (en16 != 16'h0) nz++;
            chk($sformatf("s3_en_k%0d", k), en16, e16);
            chk($sformatf("s3_done_k%0d", k), done16, (k == 31));
            if (k <= 15) chk($sformatf("s3_lane0_k%0d", k), addr16[7:0], 8'(k));
            if (k >= 15 && k <= 30) chk($sformatf("s3_lane15_k%0d", k), addr16[127:120], 8'(k - 15));
        end
        chk("s3_nonzero_cycles", nz, 31);

        // active held high, base changed mid-run
        run4("s4a", 8'h20, 8'h40, 1'b1, -1);
        run4("s4b", 8'h40, 8'h40, 1'b0, -1);
        step();
        chk("s4_after_en", en4, 4'h0);
        chk("s4_after_busy", busy4, 1'b0);

        // Reset in the middle of a run
        base4 = 8'h10; act4 = 1'b1;
        step();
        act4 = 1'b0;
        for (int k = 1; k < 5; k++) step();
        chk("s5_pre_en", en4, 4'hE);
        #2 reset = 1'b0;
        #1;
        chk("s5_rst_en",   en4,   4'h0);
        chk("s5_rst_addr", addr4, 32'h0);
        chk("s5_rst_busy", busy4, 1'b0);
        chk("s5_rst_done", done4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s5_hold_done", done4, 1'b0);
            chk("s5_hold_en",   en4,   4'h0);
        end
        reset = 1'b1;
        step();
        chk("s5_post_en",   en4,   4'h0);
        chk("s5_post_done", done4, 1'b0);
        run4("s5b", 8'h10, 8'h10, 1'b0, -1);

        // active while busy is ignored
        step();
        run4("s6", 8'h30, 8'h30, 1'b0, 2);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s6_idle_en",   en4,   4'h0);
            chk("s6_idle_done", done4, 1'b0);
            chk("s6_idle_busy", busy4, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
